// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Transfer state, kept as plain 2-bit constants for compatibility with older tools.
  typedef logic [1:0] apb_state_t;
  localparam apb_state_t StIdle   = 2'd0;
  localparam apb_state_t StSetup  = 2'd1;
  localparam apb_state_t StAccess = 2'd2;
  localparam apb_state_t StResp   = 2'd3;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; expired flags the last permitted pready-low cycle.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A zero TIMEOUT still needs a legal 1-bit counter even though it never expires.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over enable so a fresh transfer always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (TIMEOUT == 0) begin : g_no_timeout
    assign expired = 1'b0;
  end else begin : g_timeout
    assign expired = (cnt_q == CntW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB requester with a per-transfer pready timeout.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_t        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic ctr_clr, ctr_en, ctr_expired;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .pclk    (pclk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  // Next-state and next-output decode; every output is the registered copy of a _d value.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        ctr_clr   = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (ctr_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          ctr_en = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; address/data deliberately hold their value between transfers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: register-slave model, response scoreboard, vector table.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int unsigned TO = 16;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  // Register-slave model: pready on ACCESS cycle wait_n+1, or never when hung.
  logic [31:0] mem [16];
  int unsigned acc_cnt;
  int unsigned wait_n = 2;
  logic        hung   = 1'b0;
  logic        pulse  = 1'b0;

  assign pready = pulse | (!hung && psel && penable && (acc_cnt == wait_n));
  assign prdata = mem[paddr[5:2]];

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      acc_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed at command handshake, popped at response handshake.
  logic [31:0] ref_mem [16];
  apb_rsp_t    sb [$];

  always @(negedge pclk or negedge rst) begin
    if (!rst) begin
      sb.delete();
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        apb_rsp_t e;
        if (hung) begin
          e = '{rdata: 32'h0, err: 1'b1};
        end else if (cmd_write) begin
          e = '{rdata: 32'h0, err: 1'b0};
          ref_mem[cmd_addr[5:2]] = cmd_wdata;
        end else begin
          e = '{rdata: ref_mem[cmd_addr[5:2]], err: 1'b0};
        end
        sb.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'h1, 32'h0);
        end else begin
          apb_rsp_t e;
          e = sb.pop_front();
          chk("sb_rdata", rsp_rdata, e.rdata);
          chk("sb_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input apb_cmd_t c);
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_valid = 1'b1;
  endtask

  // Waits for cmd_ready, then steps over the accepting edge.
  task automatic accept(output bit ok);
    int n = 0;
    while (!cmd_ready && n < 60) begin
      step();
      n++;
    end
    ok = cmd_ready;
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    step();
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    ok = rsp_valid;
    if (!ok) chk("rsp_timeout", 32'h0, 32'h1);
  endtask

  task automatic run_cmd(input apb_cmd_t c, output apb_rsp_t r, output logic bus_busy,
                         output bit ok);
    bit a_ok, r_ok;
    drive_cmd(c);
    accept(a_ok);
    cmd_valid = 1'b0;
    wait_rsp(r_ok);
    r        = '{rdata: rsp_rdata, err: rsp_err};
    bus_busy = psel | penable;
    ok       = a_ok && r_ok;
    step();
  endtask

  typedef struct {
    apb_cmd_t cmd;
    apb_rsp_t exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    apb_rsp_t r;
    logic     busy;
    bit       ok;
    int       n;
    int       rise0, rise1, idle_cnt, cyc;
    logic     prev_psel;
    logic [31:0] held;

    vecs[0] = '{cmd: '{1'b0, 32'h0, 32'h0},        exp: '{32'hDEADBEEF, 1'b0}};
    vecs[1] = '{cmd: '{1'b1, 32'h4, 32'h12345678}, exp: '{32'h0, 1'b0}};
    vecs[2] = '{cmd: '{1'b1, 32'h8, 32'hA5A5A5A5}, exp: '{32'h0, 1'b0}};
    vecs[3] = '{cmd: '{1'b0, 32'h4, 32'h0},        exp: '{32'h12345678, 1'b0}};
    vecs[4] = '{cmd: '{1'b0, 32'h8, 32'h0},        exp: '{32'hA5A5A5A5, 1'b0}};
    vecs[5] = '{cmd: '{1'b0, 32'hC, 32'h0},        exp: '{32'h0, 1'b0}};
    vecs[6] = '{cmd: '{1'b1, 32'h0, 32'hFFFFFFFF}, exp: '{32'h0, 1'b0}};
    vecs[7] = '{cmd: '{1'b0, 32'h0, 32'h0},        exp: '{32'hFFFFFFFF, 1'b0}};

    // Reset values.
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    step();
    rst = 1'b1;
    step();

    // Write with phase timing against the 3-cycle slave.
    drive_cmd('{1'b1, 32'h0, 32'hDEADBEEF});
    chk("wr_idle_ready", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel", 32'(psel), 32'h1);
    chk("wr_setup_penable", 32'(penable), 32'h0);
    chk("wr_setup_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("wr_setup_pwrite", 32'(pwrite), 32'h1);
    step();
    chk("wr_access_penable", 32'(penable), 32'h1);
    n = 0;
    while (penable && n < 40) begin
      chk("wr_pwdata_stable", pwdata, 32'hDEADBEEF);
      n++;
      step();
    end
    chk("wr_access_cycles", 32'(n), 32'd3);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_psel_low", 32'(psel), 32'h0);
    step();

    // Table of read/write transfers.
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].cmd, r, busy, ok);
      if (ok) begin
        chk($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].exp.rdata);
        chk($sformatf("vec%0d_err", i), 32'(r.err), 32'(vecs[i].exp.err));
        chk($sformatf("vec%0d_bus_idle", i), 32'(busy), 32'h0);
      end
    end

    // Response backpressure with a second command waiting.
    rsp_ready = 1'b0;
    drive_cmd('{1'b0, 32'h4, 32'h0});
    accept(ok);
    drive_cmd('{1'b1, 32'h14, 32'h5555AAAA});
    wait_rsp(ok);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rdata_stable", rsp_rdata, held);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_psel", 32'(psel), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("bp_release_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("bp_release_psel", 32'(psel), 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("bp_second_psel", 32'(psel), 32'h1);
    wait_rsp(ok);
    step();

    // Back-to-back against a zero-wait slave.
    wait_n = 0;
    drive_cmd('{1'b1, 32'h10, 32'h11112222});
    rise0 = -1; rise1 = -1; idle_cnt = 0; prev_psel = psel;
    for (cyc = 0; cyc < 30 && rise1 < 0; cyc++) begin
      step();
      if (psel && !prev_psel) begin
        if (rise0 < 0) begin
          rise0 = cyc;
          drive_cmd('{1'b0, 32'h10, 32'h0});
        end else begin
          rise1 = cyc;
          cmd_valid = 1'b0;
        end
      end else if (rise0 >= 0 && cmd_ready) begin
        idle_cnt++;
      end
      prev_psel = psel;
    end
    cmd_valid = 1'b0;
    chk("b2b_psel_interval", 32'(rise1 - rise0), 32'd4);
    chk("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
    wait_rsp(ok);
    chk("b2b_read_back", rsp_rdata, 32'h11112222);
    step();

    // Hung slave: timeout abort, then a stray pready pulse.
    hung      = 1'b1;
    rsp_ready = 1'b0;
    drive_cmd('{1'b0, 32'h8, 32'h0});
    accept(ok);
    cmd_valid = 1'b0;
    chk("hung_setup_penable", 32'(penable), 32'h0);
    step();
    n = 0;
    while (penable && n < 100) begin
      n++;
      step();
    end
    chk("hung_penable_cycles", 32'(n), TO);
    chk("hung_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("hung_rsp_err", 32'(rsp_err), 32'h1);
    chk("hung_rsp_rdata", rsp_rdata, 32'h0);
    chk("hung_psel", 32'(psel), 32'h0);
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    chk("hung_pulse_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("hung_pulse_rsp_err", 32'(rsp_err), 32'h1);
    chk("hung_pulse_psel", 32'(psel), 32'h0);
    chk("hung_pulse_penable", 32'(penable), 32'h0);
    rsp_ready = 1'b1;
    step();
    hung = 1'b0;
    chk("hung_done_cmd_ready", 32'(cmd_ready), 32'h1);

    // Reset in the middle of ACCESS drops the transfer.
    wait_n = 100;
    drive_cmd('{1'b0, 32'h0, 32'h0});
    accept(ok);
    cmd_valid = 1'b0;
    step();
    chk("rstmid_penable", 32'(penable), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstmid_psel", 32'(psel), 32'h0);
    chk("rstmid_penable_low", 32'(penable), 32'h0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    step();
    rst = 1'b1;
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'h1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) n++;
      step();
    end
    chk("rstmid_no_rsp", 32'(n), 32'h0);

    // Recovery transfer; slave contents were cleared by reset.
    wait_n = 2;
    run_cmd('{1'b0, 32'h4, 32'h0}, r, busy, ok);
    if (ok) chk("post_rst_rdata", r.rdata, 32'h0);

    step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
